// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter and its helpers.
package uart_arb_pkg;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } arb_state_e;

    // Largest number of requesters the arbiter supports.
    localparam int unsigned ARB_MAX_REQ = 8;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side handshake and UART-side transmit signals of the arbiter.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 uart_transmit;
    logic [7:0]           uart_tx_byte;
    logic                 uart_is_transmitting;

    // Producers plus UART: drive requests and UART status, observe the arbiter.
    modport master (
        output req_valid,
        output req_data,
        output uart_is_transmitting,
        input  req_ready,
        input  uart_transmit,
        input  uart_tx_byte
    );

    // Arbiter: consumes requests and UART status, drives the UART inputs.
    modport slave (
        input  req_valid,
        input  req_data,
        input  uart_is_transmitting,
        output req_ready,
        output uart_transmit,
        output uart_tx_byte
    );
endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin select: first set request after rr_last, wrapping.
module rr_picker #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_last,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic                       any_valid
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic             found;
    logic [IDX_W-1:0] lane;

    // Scan rr_last+1, rr_last+2, ... modulo NUM_REQ and keep the first hit.
    always_comb begin
        winner    = '0;
        found     = 1'b0;
        lane      = '0;
        any_valid = |req;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            lane = IDX_W'((32'(rr_last) + i) % NUM_REQ);
            if (!found && req[lane]) begin
                winner = lane;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ producers.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned START_TIMEOUT = 1023,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    uart_tx_arbiter_if.slave           bus,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       tx_timeout,
    output logic [CNT_W-1:0]           sent_count
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned TO_W  = (START_TIMEOUT > 0) ? $clog2(START_TIMEOUT + 1) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(START_TIMEOUT);

    if (NUM_REQ < 2 || NUM_REQ > ARB_MAX_REQ) begin : g_bad_num_req
        $error("uart_tx_arbiter: NUM_REQ must be in 2..%0d", ARB_MAX_REQ);
    end

    arb_state_e         state_q,    state_d;
    logic               transmit_q, transmit_d;
    logic [7:0]         tx_byte_q,  tx_byte_d;
    logic [NUM_REQ-1:0] ready_q,    ready_d;
    logic [IDX_W-1:0]   grant_q,    grant_d;
    logic [IDX_W-1:0]   rr_last_q,  rr_last_d;
    logic               busy_q,     busy_d;
    logic               timeout_q,  timeout_d;
    logic [TO_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]   sent_q,     sent_d;

    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req       (bus.req_valid),
        .rr_last   (rr_last_q),
        .winner    (pick_idx),
        .any_valid (pick_any)
    );

    // Next-state and next-output computation for the grant/issue/wait sequence.
    always_comb begin
        state_d    = state_q;
        transmit_d = transmit_q;
        tx_byte_d  = tx_byte_q;
        ready_d    = '0;
        grant_d    = grant_q;
        rr_last_d  = rr_last_q;
        timeout_d  = timeout_q;
        wait_cnt_d = wait_cnt_q;
        sent_d     = sent_q;

        unique case (state_q)
            IDLE: begin
                // A busy UART here may be a frame left over from before reset.
                if (pick_any && !bus.uart_is_transmitting) begin
                    tx_byte_d         = bus.req_data[{pick_idx, 3'b000} +: 8];
                    grant_d           = pick_idx;
                    rr_last_d         = pick_idx;
                    ready_d[pick_idx] = 1'b1;
                    transmit_d        = 1'b1;
                    wait_cnt_d        = '0;
                    state_d           = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.uart_is_transmitting) begin
                    transmit_d = 1'b0;
                    state_d    = WAIT_DONE;
                end else if (wait_cnt_q == TO_LAST) begin
                    transmit_d = 1'b0;
                    timeout_d  = 1'b1;
                    state_d    = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                transmit_d = 1'b0;
                if (!bus.uart_is_transmitting) begin
                    sent_d  = sent_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                transmit_d = 1'b0;
                state_d    = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            transmit_q <= 1'b0;
            tx_byte_q  <= 8'h00;
            ready_q    <= '0;
            grant_q    <= '0;
            rr_last_q  <= IDX_W'(NUM_REQ - 1);
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            wait_cnt_q <= '0;
            sent_q     <= '0;
        end else begin
            state_q    <= state_d;
            transmit_q <= transmit_d;
            tx_byte_q  <= tx_byte_d;
            ready_q    <= ready_d;
            grant_q    <= grant_d;
            rr_last_q  <= rr_last_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
            wait_cnt_q <= wait_cnt_d;
            sent_q     <= sent_d;
        end
    end

    assign bus.uart_transmit = transmit_q;
    assign bus.uart_tx_byte  = tx_byte_q;
    assign bus.req_ready     = ready_q;
    assign grant_id          = grant_q;
    assign busy              = busy_q;
    assign tx_timeout        = timeout_q;
    assign sent_count        = sent_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with an inline UART and requester model.
module tb_uart_tx_arbiter;
    localparam int unsigned NR = 4;
    localparam int unsigned TO = 15;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    grant_id;
    logic          busy;
    logic          tx_timeout;
    logic [CW-1:0] sent_count;

    uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ       (NR),
        .START_TIMEOUT (TO),
        .CNT_W         (CW)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .grant_id   (grant_id),
        .busy       (busy),
        .tx_timeout (tx_timeout),
        .sent_count (sent_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    int         model_last;
    int         model_sent;
    int         done_frames = 0;
    logic [7:0] exp_q[$];
    logic [7:0] uart_log[$];
    int         grant_log[$];

    // UART model: 0 = responds, 1 = never starts, 2 = status driven by test.
    int         uart_mode = 0;
    int         uphase = 0;
    int         ucnt = 0;
    logic [7:0] ubyte = 8'h00;
    bit         pend_done = 1'b0;
    bit         rand_req = 1'b0;
    bit         hold_stop = 1'b0;
    int         stop_at = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first valid lane after the last winner, wrapping.
    function automatic int pick(input logic [NR-1:0] m, input int last);
        for (int k = 1; k <= int'(NR); k++) begin
            if (m[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    task automatic step();
        int lane;
        logic [7:0] d;
        @(posedge clk);
        #1;
        if (!rst_n) return;
        if (pend_done) begin
            pend_done   = 1'b0;
            model_sent  = (model_sent + 1) % (1 << CW);
            done_frames++;
            chk("sent_count", 32'(sent_count), 32'(model_sent));
        end
        if (bus.req_ready != '0) begin
            lane = pick(bus.req_valid, model_last);
            if (lane < 0) begin
                chk("ready_without_request", 32'(bus.req_ready), 32'd0);
            end else begin
                d = bus.req_data[8*lane +: 8];
                chk("ready_lane", 32'(bus.req_ready), 32'(1 << lane));
                chk("grant_id", 32'(grant_id), 32'(lane));
                chk("grant_byte", 32'(bus.uart_tx_byte), 32'(d));
                chk("grant_transmit", 32'(bus.uart_transmit), 32'd1);
                chk("grant_uart_idle", 32'(bus.uart_is_transmitting), 32'd0);
                model_last = lane;
                exp_q.push_back(d);
                grant_log.push_back(lane);
                if (rand_req) begin
                    bus.req_valid[lane]       = 1'($urandom_range(0, 1));
                    bus.req_data[8*lane +: 8] = 8'($urandom);
                end
            end
        end
        if (rand_req) begin
            for (int i = 0; i < int'(NR); i++) begin
                if (!bus.req_valid[i] && $urandom_range(0, 3) == 0) begin
                    bus.req_valid[i]       = 1'b1;
                    bus.req_data[8*i +: 8] = 8'($urandom);
                end else if (bus.req_valid[i] && $urandom_range(0, 39) == 0) begin
                    bus.req_valid[i] = 1'b0;
                end
            end
        end
        if (hold_stop && grant_log.size() >= stop_at) bus.req_valid = '0;
        if (uart_mode == 0) begin
            if (uphase == 0 && bus.uart_transmit) begin
                if (exp_q.size() == 0) chk("uart_start_unexpected", 32'd1, 32'd0);
                else chk("uart_byte", 32'(bus.uart_tx_byte), 32'(exp_q.pop_front()));
                ubyte = bus.uart_tx_byte;
                uart_log.push_back(ubyte);
                ucnt   = $urandom_range(0, 3);
                uphase = 1;
            end
            if (uphase == 1) begin
                if (ucnt == 0) begin
                    bus.uart_is_transmitting = 1'b1;
                    ucnt   = $urandom_range(1, 5);
                    uphase = 2;
                end else begin
                    ucnt--;
                end
            end else if (uphase == 2) begin
                chk("byte_stable", 32'(bus.uart_tx_byte), 32'(ubyte));
                ucnt--;
                if (ucnt == 0) begin
                    bus.uart_is_transmitting = 1'b0;
                    uphase    = 0;
                    pend_done = 1'b1;
                end
            end
        end
    endtask

    task automatic clear_model();
        model_last = NR - 1;
        model_sent = 0;
        exp_q.delete();
        uphase    = 0;
        pend_done = 1'b0;
    endtask

    task automatic check_reset_values();
        chk("rst_transmit", 32'(bus.uart_transmit), 32'd0);
        chk("rst_tx_byte", 32'(bus.uart_tx_byte), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tx_timeout", 32'(tx_timeout), 32'd0);
        chk("rst_sent_count", 32'(sent_count), 32'd0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.uart_is_transmitting = 1'b0;
        uart_mode = 0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        rst_n = 1'b1;
    endtask

    task automatic run_until_frames(input int target, input int budget);
        int b;
        b = budget;
        while (done_frames < target && b > 0) begin
            step();
            b--;
        end
        if (done_frames < target) chk("frame_wait_expired", 32'(done_frames), 32'(target));
    endtask

    task automatic run_until_idle(input int budget);
        int b;
        b = budget;
        while ((busy || uphase != 0 || pend_done) && b > 0) begin
            step();
            b--;
        end
        if (busy || uphase != 0 || pend_done) chk("idle_wait_expired", 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int base;

        // Reset values.
        apply_reset();

        // Single request on lane 2.
        bus.req_data[8*2 +: 8] = 8'h41;
        bus.req_valid = 4'b0100;
        step();
        chk("single_ready", 32'(bus.req_ready), 32'h4);
        chk("single_transmit", 32'(bus.uart_transmit), 32'd1);
        chk("single_byte", 32'(bus.uart_tx_byte), 32'h41);
        bus.req_valid = '0;
        step();
        chk("single_ready_pulse", 32'(bus.req_ready), 32'd0);
        run_until_frames(done_frames + 1, 60);
        chk("single_sent", 32'(sent_count), 32'd1);
        run_until_idle(40);

        // All lanes held valid for 8 frames.
        apply_reset();
        grant_log.delete();
        uart_log.delete();
        for (int i = 0; i < int'(NR); i++) bus.req_data[8*i +: 8] = 8'(8'h10 + i);
        bus.req_valid = 4'hF;
        hold_stop = 1'b1;
        stop_at   = 8;
        run_until_frames(done_frames + 8, 400);
        hold_stop = 1'b0;
        run_until_idle(40);
        chk("fair_grant_count", 32'(grant_log.size()), 32'd8);
        chk("fair_byte_count", 32'(uart_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < grant_log.size() && i < uart_log.size(); i++) begin
            chk("fair_grant_order", 32'(grant_log[i]), 32'(i % 4));
            chk("fair_byte_order", 32'(uart_log[i]), 32'(8'h10 + i % 4));
        end

        // UART never starts: timeout.
        uart_mode = 1;
        base = model_sent;
        bus.req_data[8*1 +: 8] = 8'h55;
        bus.req_valid = 4'b0010;
        step();
        chk("to_ready", 32'(bus.req_ready), 32'h2);
        bus.req_valid = '0;
        cnt = 0;
        for (int i = 0; i < 60 && bus.uart_transmit; i++) begin
            cnt++;
            step();
        end
        chk("to_transmit_cycles", 32'(cnt), 32'(TO + 1));
        chk("to_flag", 32'(tx_timeout), 32'd1);
        chk("to_busy", 32'(busy), 32'd0);
        chk("to_sent_unchanged", 32'(sent_count), 32'(base));
        exp_q.delete();
        uart_mode = 0;
        bus.req_data[8*0 +: 8] = 8'h66;
        bus.req_valid = 4'b0001;
        step();
        chk("to_next_ready", 32'(bus.req_ready), 32'h1);
        bus.req_valid = '0;
        run_until_frames(done_frames + 1, 60);
        run_until_idle(40);
        chk("to_flag_sticky", 32'(tx_timeout), 32'd1);

        // UART busy at start blocks the grant.
        apply_reset();
        uart_mode = 2;
        bus.uart_is_transmitting = 1'b1;
        bus.req_data[8*0 +: 8] = 8'h77;
        bus.req_valid = 4'b0001;
        repeat (5) begin
            step();
            chk("blocked_no_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.uart_is_transmitting = 1'b0;
        uphase = 0;
        uart_mode = 0;
        step();
        chk("unblocked_ready", 32'(bus.req_ready), 32'h1);
        bus.req_valid = '0;
        run_until_frames(done_frames + 1, 60);
        run_until_idle(40);

        // Reset in WAIT_DONE with the UART still busy.
        uart_mode = 2;
        bus.req_data[8*3 +: 8] = 8'h99;
        bus.req_valid = 4'b1000;
        step();
        chk("mid_ready", 32'(bus.req_ready), 32'h8);
        bus.req_valid = '0;
        step();
        bus.uart_is_transmitting = 1'b1;
        step();
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_transmit_low", 32'(bus.uart_transmit), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_transmit", 32'(bus.uart_transmit), 32'd0);
        chk("async_sent", 32'(sent_count), 32'd0);
        clear_model();
        bus.req_data[8*3 +: 8] = 8'hAA;
        bus.req_valid = 4'b1000;
        #1;
        rst_n = 1'b1;
        repeat (4) begin
            step();
            chk("post_reset_no_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.uart_is_transmitting = 1'b0;
        uart_mode = 0;
        step();
        chk("post_reset_ready", 32'(bus.req_ready), 32'h8);
        bus.req_valid = '0;
        run_until_frames(done_frames + 1, 60);
        run_until_idle(40);

        // Randomized traffic against the model.
        for (int i = 0; i < int'(NR); i++) bus.req_data[8*i +: 8] = 8'($urandom);
        bus.req_valid = 4'($urandom);
        rand_req = 1'b1;
        repeat (1500) step();
        rand_req = 1'b0;
        bus.req_valid = '0;
        run_until_idle(60);

        // Counter wrap: 2^CW + 1 frames.
        apply_reset();
        grant_log.delete();
        for (int i = 0; i < int'(NR); i++) bus.req_data[8*i +: 8] = 8'(8'hC0 + i);
        bus.req_valid = 4'hF;
        hold_stop = 1'b1;
        stop_at   = (1 << CW) + 1;
        run_until_frames(done_frames + (1 << CW) + 1, 1000);
        hold_stop = 1'b0;
        run_until_idle(40);
        chk("sent_wrap", 32'(sent_count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
